ascon_sub_layer_iter: RTL and testbench

- Iterative Ascon substitution layer (pS) for the 320-bit permutation state.
- Applies the 5-bit Ascon S-box column-wise to all 64 columns, COLS_PER_CYCLE columns per clock.
- Sits downstream of the constant-addition stage and upstream of the linear diffusion layer (pL).
- Trades latency for area against a fully parallel 64-S-box layer.

---
 rtl/ascon_sub_layer_iter.sv | 147 ++++++++++++++
 tb/tb_ascon_sub_layer_iter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_sub_layer_iter.sv
// ascon_sub_layer_iter
// ---------------------------------------------------------------------------
// Iterative Ascon substitution layer (pS) for the 320-bit permutation state.
// The 5-bit Ascon S-box is applied column-wise to all 64 columns, with
// COLS_PER_CYCLE columns substituted per RUN cycle. This trades latency for
// area compared with a fully parallel 64-S-box layer. The block sits between
// the constant-addition stage and the linear diffusion layer (pL).
//
// Parameters:
//   COLS_PER_CYCLE  S-boxes instantiated (1,2,4,8,16,32,64); RUN lasts
//                   64/COLS_PER_CYCLE cycles.
//
// Ports:
//   clock_i   in   1    system clock, rising edge
//   reset_i   in   1    synchronous active-high reset
//   abort_i   in   1    only with ASCON_SUB_ABORT_EN: drop current work, keep data
//   valid_i   in   1    input state valid (looked at only in IDLE)
//   ready_o   out  1    block can accept a state
//   state_i   in   320  input state, x0 in bits 319:256 ... x4 in bits 63:0
//   valid_o   out  1    substituted state available
//   ready_i   in   1    downstream accepts output (looked at only in OUT)
//   state_o   out  320  substituted state, same packing as state_i
//
// Optional feature macro: ASCON_SUB_ABORT_EN (adds abort_i).
// ---------------------------------------------------------------------------
module ascon_sub_layer_iter #(
   parameter int COLS_PER_CYCLE = 8
) (
   input  logic         clock_i,
   input  logic         reset_i,
`ifdef ASCON_SUB_ABORT_EN
   input  logic         abort_i,
`endif
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [319:0] state_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [319:0] state_o
);

   localparam int N_STEPS = 64 / COLS_PER_CYCLE;
   localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   localparam int COL_SH  = $clog2(COLS_PER_CYCLE);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

   // Ascon S-box, indexed by the 5-bit column value (x0 is bit 4).
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };

   typedef enum logic [1:0] {IDLE, RUN, OUT} fsm_t;

   fsm_t              fsm_q;
   logic [STEP_W-1:0] step_q;
   // Element k holds word x(4-k), so element 4 (x0) supplies the S-box MSB
   // and the packed vector matches the state_i/state_o layout directly.
   logic [4:0][63:0]  data_q;
   logic [4:0][63:0]  sub_data;
   logic [5:0]        base_col;

   // Substitute the current window of columns; everything else passes through.
   always_comb begin
      // NOTE: every always_comb output gets a full default first so no path
      // leaves it unassigned and no latch is inferred.
      sub_data = data_q;
      base_col = 6'(step_q) << COL_SH;
      for (int c = 0; c < COLS_PER_CYCLE; c++) begin
         logic [5:0] col;
         logic [4:0] s_in;
         logic [4:0] s_out;
         col = base_col | 6'(c);
         for (int k = 0; k < 5; k++) begin
            s_in[k] = data_q[k][col];
         end
         s_out = SBOX[s_in];
         for (int k = 0; k < 5; k++) begin
            sub_data[k][col] = s_out[k];
         end
      end
   end

   // FSM, step counter, state register and registered handshake outputs.
   always_ff @(posedge clock_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees pre-edge values regardless of statement order.
      if (reset_i) begin
         fsm_q   <= IDLE;
         step_q  <= '0;
         // NOTE: the wide data register is reset too, so state_o is
         // deterministic (all-zero) after reset even though it is don't-care.
         data_q  <= '0;
         ready_o <= 1'b1;
         valid_o <= 1'b0;
      end
`ifdef ASCON_SUB_ABORT_EN
      else if (abort_i) begin
         // Same as reset, but the data register keeps its contents.
         fsm_q   <= IDLE;
         step_q  <= '0;
         ready_o <= 1'b1;
         valid_o <= 1'b0;
      end
`endif
      else begin
         case (fsm_q)
            IDLE: begin
               if (valid_i) begin
                  data_q  <= state_i;
                  step_q  <= '0;
                  fsm_q   <= RUN;
                  ready_o <= 1'b0;
               end
            end
            RUN: begin
               data_q <= sub_data;
               if (step_q == LAST_STEP) begin
                  // Counter is held on the last step so it never wraps.
                  fsm_q   <= OUT;
                  valid_o <= 1'b1;
               end else begin
                  step_q <= step_q + STEP_W'(1);
               end
            end
            OUT: begin
               if (ready_i) begin
                  fsm_q   <= IDLE;
                  valid_o <= 1'b0;
                  ready_o <= 1'b1;
               end
            end
            default: begin
               fsm_q   <= IDLE;
               step_q  <= '0;
               ready_o <= 1'b1;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = data_q;

endmodule

// File: tb/tb_ascon_sub_layer_iter.sv
// tb_ascon_sub_layer_iter
// ---------------------------------------------------------------------------
// Self-checking bench for ascon_sub_layer_iter. Three instances are built
// with COLS_PER_CYCLE = 8, 1 and 64. A word-level reference model computes
// the substituted state and the expected handshake timing; a single compare
// process checks every instance against it on every cycle, and directed
// tests pin the model with hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_ascon_sub_layer_iter;

   localparam int NDUT = 3;

   // Spec S-box table, inputs 0x00..0x1F.
   localparam logic [7:0] SB [32] = '{
      8'h04, 8'h0B, 8'h1F, 8'h14, 8'h1A, 8'h15, 8'h09, 8'h02,
      8'h1B, 8'h05, 8'h08, 8'h12, 8'h1D, 8'h03, 8'h06, 8'h1C,
      8'h1E, 8'h13, 8'h07, 8'h0E, 8'h00, 8'h0D, 8'h11, 8'h18,
      8'h10, 8'h0C, 8'h01, 8'h19, 8'h16, 8'h0A, 8'h0F, 8'h17
   };

   localparam logic [63:0]  ONES64    = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [319:0] ZERO_OUT  = {64'h0, 64'h0, ONES64, 64'h0, 64'h0};
   localparam logic [319:0] ONES_OUT  = {ONES64, 64'h0, ONES64, ONES64, ONES64};
   localparam logic [319:0] COL_IN    = {64'h0, 64'h0, 64'h0, 64'h0, 64'h1};
   localparam logic [319:0] COL_OUT   = {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1};

   logic         clk;
   logic         reset_i [NDUT];
   logic         valid_i [NDUT];
   logic         ready_i [NDUT];
   logic [319:0] state_i [NDUT];
   logic         ready_o [NDUT];
   logic         valid_o [NDUT];
   logic [319:0] state_o [NDUT];

   int passed = 0;
   int total  = 0;

   // Model state
   int           cyc = 0;
   bit           pending [NDUT] = '{1'b0, 1'b0, 1'b0};
   int           acc     [NDUT] = '{0, 0, 0};
   logic [319:0] exp_state [NDUT];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ascon_sub_layer_iter #(
         .COLS_PER_CYCLE(g == 0 ? 8 : (g == 1 ? 1 : 64))
      ) u_dut (
         .clock_i (clk),
         .reset_i (reset_i[g]),
`ifdef ASCON_SUB_ABORT_EN
         .abort_i (1'b0),
`endif
         .valid_i (valid_i[g]),
         .ready_o (ready_o[g]),
         .state_i (state_i[g]),
         .valid_o (valid_o[g]),
         .ready_i (ready_i[g]),
         .state_o (state_o[g])
      );
   end

   function automatic int n_steps(input int d);
      return (d == 0) ? 8 : ((d == 1) ? 64 : 1);
   endfunction

   // Whole-state substitution: split into words, push every column through
   // the table, reassemble.
   function automatic logic [319:0] ref_sub(input logic [319:0] s);
      logic [63:0] x [5];
      logic [4:0]  v;
      logic [7:0]  o;
      for (int k = 0; k < 5; k++) x[k] = s[64*(4-k) +: 64];
      for (int j = 0; j < 64; j++) begin
         v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
         o = SB[v];
         x[0][j] = o[4];
         x[1][j] = o[3];
         x[2][j] = o[2];
         x[3][j] = o[1];
         x[4][j] = o[0];
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // Model update: acceptance / completion decided from the inputs and the
   // cycle count only.
   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         if (reset_i[d]) begin
            pending[d] = 1'b0;
         end else if (pending[d]) begin
            if ((cyc - 1 - acc[d]) >= n_steps(d) && ready_i[d]) pending[d] = 1'b0;
         end else if (valid_i[d]) begin
            pending[d]   = 1'b1;
            acc[d]       = cyc;
            exp_state[d] = ref_sub(state_i[d]);
         end
      end
   end

   // Per-cycle compare of every instance against the model.
   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int d = 0; d < NDUT; d++) begin
            automatic bit ev = pending[d] && ((cyc - acc[d]) >= n_steps(d));
            check($sformatf("cyc%0d dut%0d ready_o", cyc, d), 320'(ready_o[d]), 320'(!pending[d]));
            check($sformatf("cyc%0d dut%0d valid_o", cyc, d), 320'(valid_o[d]), 320'(ev));
            if (ev) check($sformatf("cyc%0d dut%0d state_o", cyc, d), state_o[d], exp_state[d]);
         end
      end
   end

   // One transaction: accept s, measure latency, hold off ready_i for 'hold'
   // cycles, then release and confirm return to IDLE.
   task automatic run_one(input int d, input logic [319:0] s, input int hold,
                          input bit keep_valid, output logic [319:0] got);
      int edges;
      @(negedge clk);
      valid_i[d] = 1'b1;
      state_i[d] = s;
      ready_i[d] = 1'b0;
      @(posedge clk);
      edges = 0;
      @(negedge clk);
      if (!keep_valid) valid_i[d] = 1'b0;
      state_i[d] = ~s;
      while (!valid_o[d] && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check($sformatf("dut%0d latency", d), 320'(edges), 320'(n_steps(d)));
      got = state_o[d];
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("dut%0d bp valid_o", d), 320'(valid_o[d]), 320'(1));
         check($sformatf("dut%0d bp ready_o", d), 320'(ready_o[d]), 320'(0));
         check($sformatf("dut%0d bp state_o", d), state_o[d], got);
      end
      ready_i[d] = 1'b1;
      valid_i[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ready_i[d] = 1'b0;
      check($sformatf("dut%0d idle ready_o", d), 320'(ready_o[d]), 320'(1));
      check($sformatf("dut%0d idle valid_o", d), 320'(valid_o[d]), 320'(0));
   endtask

   initial begin
      logic [319:0] got;
      logic [319:0] s;
      for (int d = 0; d < NDUT; d++) begin
         reset_i[d] = 1'b1;
         valid_i[d] = 1'b0;
         ready_i[d] = 1'b0;
         state_i[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("dut%0d reset ready_o", d), 320'(ready_o[d]), 320'(1));
         check($sformatf("dut%0d reset valid_o", d), 320'(valid_o[d]), 320'(0));
         check($sformatf("dut%0d reset state_o", d), state_o[d], '0);
         reset_i[d] = 1'b0;
      end

      // Reset on the 3rd RUN edge discards the partially processed state.
      @(negedge clk);
      valid_i[0] = 1'b1;
      state_i[0] = '1;
      @(posedge clk);
      @(negedge clk);
      valid_i[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_i[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_i[0] = 1'b0;
      check("midrun reset ready_o", 320'(ready_o[0]), 320'(1));
      check("midrun reset valid_o", 320'(valid_o[0]), 320'(0));
      check("midrun reset state_o", state_o[0], '0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("midrun no valid pulse", 320'(valid_o[0]), 320'(0));
      end

      // Hand-computed vectors, C=8.
      run_one(0, '0, 0, 1'b0, got);
      check("all-zero result", got, ZERO_OUT);
      run_one(0, '1, 0, 1'b0, got);
      check("all-ones result", got, ONES_OUT);
      run_one(0, COL_IN, 0, 1'b0, got);
      check("single-column result", got, COL_OUT);

      // Backpressure with valid_i held high through RUN/OUT.
      s = rand320();
      run_one(0, s, 5, 1'b1, got);
      check("backpressure result", got, ref_sub(s));

      // Parameter sweep C=1 and C=64.
      run_one(2, COL_IN, 0, 1'b0, got);
      check("c64 single-column result", got, COL_OUT);
      run_one(1, '1, 0, 1'b0, got);
      check("c1 all-ones result", got, ONES_OUT);
      for (int d = 1; d < NDUT; d++) begin
         for (int i = 0; i < 4; i++) begin
            s = rand320();
            run_one(d, s, i, i[0], got);
            check($sformatf("dut%0d random %0d", d, i), got, ref_sub(s));
         end
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
